// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for an async FIFO.
// Consumes the synchronized Gray write pointer; every output is a flop in the read clock domain.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_en_i,
  input  logic                  clr_underflow_i,
  input  logic [ADDR_WIDTH:0]   rq2_wptr_i,
  output logic [ADDR_WIDTH-1:0] raddr_o,
  output logic [ADDR_WIDTH:0]   rptr_o,
  output logic                  rempty_o,
  output logic                  ralmost_empty_o,
  output logic [ADDR_WIDTH:0]   rcount_o,
  output logic                  rd_ack_o,
  output logic                  runderflow_o
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AEMPTY_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ {1'b0, b[PW-1:1]};
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] rcount_q, rcount_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic          rd_ack_q, rd_ack_d;
  logic          runderflow_q, runderflow_d;
  logic          rd_accept_s;
  logic [PW-1:0] wbin_s;

  // Next-state: read acceptance and write-pointer movement fold into one update.
  always_comb begin
    rd_accept_s = rd_en_i & ~rempty_q;
    rbin_d      = rbin_q + {{ADDR_WIDTH{1'b0}}, rd_accept_s};
    rptr_d      = bin2gray(rbin_d);
    wbin_s      = gray2bin(rq2_wptr_i);
    rcount_d    = wbin_s - rbin_d;
    rempty_d    = (rptr_d == rq2_wptr_i);
    raempty_d   = (rcount_d <= AE_THRESH);
    rd_ack_d    = rd_accept_s;
    // Setting the sticky flag takes priority over clearing it.
    if (rd_en_i & rempty_q) begin
      runderflow_d = 1'b1;
    end else if (clr_underflow_i) begin
      runderflow_d = 1'b0;
    end else begin
      runderflow_d = runderflow_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbin_q       <= {PW{1'b0}};
      rptr_q       <= {PW{1'b0}};
      rcount_q     <= {PW{1'b0}};
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rd_ack_q     <= 1'b0;
      runderflow_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rcount_q     <= rcount_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      rd_ack_q     <= rd_ack_d;
      runderflow_q <= runderflow_d;
    end
  end

  assign raddr_o         = rbin_q[ADDR_WIDTH-1:0];
  assign rptr_o          = rptr_q;
  assign rempty_o        = rempty_q;
  assign ralmost_empty_o = raempty_q;
  assign rcount_o        = rcount_q;
  assign rd_ack_o        = rd_ack_q;
  assign runderflow_o    = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an occupancy-based model.
module tb_fifo_rd_ctrl;

  localparam int AW    = 4;
  localparam int AE    = 2;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_en = 1'b1;
  logic          clr_underflow = 1'b0;
  logic [PW-1:0] rq2_wptr = 5'b00010;
  logic [AW-1:0] raddr;
  logic [PW-1:0] rptr;
  logic          rempty;
  logic          ralmost_empty;
  logic [PW-1:0] rcount;
  logic          rd_ack;
  logic          runderflow;

  int wr_ptr = 3;
  int total  = 0;
  int bad    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(AE)) dut (
    .clk             (clk),
    .rst             (rst),
    .rd_en_i         (rd_en),
    .clr_underflow_i (clr_underflow),
    .rq2_wptr_i      (rq2_wptr),
    .raddr_o         (raddr),
    .rptr_o          (rptr),
    .rempty_o        (rempty),
    .ralmost_empty_o (ralmost_empty),
    .rcount_o        (rcount),
    .rd_ack_o        (rd_ack),
    .runderflow_o    (runderflow)
  );

  // Model state: number of reads taken (mod 2*depth) and current occupancy.
  typedef struct {
    int rd;
    int cnt;
    bit empty;
    bit aempty;
    bit ack;
    bit uf;
  } mstate_t;

  mstate_t m;

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] v;
    v = b[PW-1:0];
    return v ^ (v >> 1);
  endfunction

  function automatic mstate_t step(input mstate_t s, input bit r, input bit rd,
                                   input bit clr, input int wr);
    mstate_t n;
    int acc;
    if (r) begin
      n.rd = 0; n.cnt = 0; n.empty = 1'b1; n.aempty = 1'b1; n.ack = 1'b0; n.uf = 1'b0;
    end else begin
      acc      = (rd && !s.empty) ? 1 : 0;
      n.rd     = (s.rd + acc) % PMOD;
      n.cnt    = (wr - n.rd + PMOD) % PMOD;
      n.empty  = (n.cnt == 0);
      n.aempty = (n.cnt <= AE);
      n.ack    = (acc == 1);
      n.uf     = (rd && s.empty) ? 1'b1 : (clr ? 1'b0 : s.uf);
    end
    return n;
  endfunction

  always @(posedge clk) m <= step(m, rst, rd_en, clr_underflow, wr_ptr);

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_raddr",  int'(raddr),         m.rd % DEPTH);
      chk("m_rptr",   int'(rptr),          int'(gray(m.rd)));
      chk("m_rcount", int'(rcount),        m.cnt);
      chk("m_rempty", int'(rempty),        int'(m.empty));
      chk("m_aempty", int'(ralmost_empty), int'(m.aempty));
      chk("m_rd_ack", int'(rd_ack),        int'(m.ack));
      chk("m_uflow",  int'(runderflow),    int'(m.uf));
    end
  end

  task automatic apply(input bit r, input bit rd, input bit c, input int wr);
    rst           = r;
    rd_en         = rd;
    clr_underflow = c;
    wr_ptr        = wr % PMOD;
    rq2_wptr      = gray(wr_ptr);
  endtask

  task automatic drive(input bit r, input bit rd, input bit c, input int wr);
    @(negedge clk);
    #1;
    apply(r, rd, c, wr);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    settle();
    chk("rst_rempty", int'(rempty), 1);
    chk("rst_aempty", int'(ralmost_empty), 1);
    chk("rst_rptr",   int'(rptr), 0);
    chk("rst_rcount", int'(rcount), 0);
    chk("rst_raddr",  int'(raddr), 0);
    chk("rst_ack",    int'(rd_ack), 0);
    chk("rst_uflow",  int'(runderflow), 0);

    drive(1'b0, 1'b0, 1'b0, 3); settle();
    chk("fill_rempty", int'(rempty), 0);
    chk("fill_rcount", int'(rcount), 3);
    chk("fill_aempty", int'(ralmost_empty), 0);

    drive(1'b0, 1'b1, 1'b0, 3); settle();
    chk("dr1_rcount", int'(rcount), 2);
    chk("dr1_raddr",  int'(raddr), 1);
    chk("dr1_ack",    int'(rd_ack), 1);
    chk("dr1_aempty", int'(ralmost_empty), 1);
    drive(1'b0, 1'b1, 1'b0, 3); settle();
    chk("dr2_rcount", int'(rcount), 1);
    chk("dr2_raddr",  int'(raddr), 2);
    drive(1'b0, 1'b1, 1'b0, 3); settle();
    chk("dr3_rcount", int'(rcount), 0);
    chk("dr3_rempty", int'(rempty), 1);
    chk("dr3_rptr",   int'(rptr), 2);
    chk("dr3_ack",    int'(rd_ack), 1);

    drive(1'b0, 1'b1, 1'b0, 3); settle();
    chk("uf_set",   int'(runderflow), 1);
    chk("uf_raddr", int'(raddr), 3);
    chk("uf_ack",   int'(rd_ack), 0);
    drive(1'b0, 1'b0, 1'b0, 3); settle();
    chk("uf_hold", int'(runderflow), 1);
    drive(1'b0, 1'b0, 1'b1, 3); settle();
    chk("uf_clr", int'(runderflow), 0);
    drive(1'b0, 1'b1, 1'b1, 3); settle();
    chk("uf_setwins", int'(runderflow), 1);
    drive(1'b0, 1'b0, 1'b1, 3); settle();
    chk("uf_clr2", int'(runderflow), 0);

    drive(1'b0, 1'b0, 1'b0, 19); settle();
    chk("full1_rcount", int'(rcount), 16);
    chk("full1_aempty", int'(ralmost_empty), 0);
    repeat (16) drive(1'b0, 1'b1, 1'b0, 19);
    settle();
    chk("pre_rempty", int'(rempty), 1);
    chk("pre_raddr",  int'(raddr), 3);
    drive(1'b0, 1'b0, 1'b0, 30);
    repeat (11) drive(1'b0, 1'b1, 1'b0, 30);
    settle();
    chk("pre30_raddr", int'(raddr), 14);
    drive(1'b0, 1'b0, 1'b0, 46); settle();
    chk("wrap_rcount", int'(rcount), 16);
    chk("wrap_rptr",   int'(rptr), 17);
    chk("wrap_rempty", int'(rempty), 0);
    drive(1'b0, 1'b1, 1'b0, 14); settle();
    chk("wrap1_raddr",  int'(raddr), 15);
    chk("wrap1_rptr",   int'(rptr), 16);
    chk("wrap1_rcount", int'(rcount), 15);
    drive(1'b0, 1'b1, 1'b0, 14); settle();
    chk("wrap2_raddr",  int'(raddr), 0);
    chk("wrap2_rptr",   int'(rptr), 0);
    chk("wrap2_rcount", int'(rcount), 14);

    repeat (13) drive(1'b0, 1'b1, 1'b0, 14);
    settle();
    chk("sim_pre_rcount", int'(rcount), 1);
    drive(1'b0, 1'b1, 1'b0, 15); settle();
    chk("sim_rcount", int'(rcount), 1);
    chk("sim_rempty", int'(rempty), 0);
    chk("sim_ack",    int'(rd_ack), 1);
    chk("sim_raddr",  int'(raddr), 14);

    drive(1'b0, 1'b0, 1'b0, 19); settle();
    chk("mid_rcount", int'(rcount), 5);
    drive(1'b1, 1'b1, 1'b0, 0); settle();
    chk("mid_rcount0", int'(rcount), 0);
    chk("mid_rempty",  int'(rempty), 1);
    chk("mid_ack",     int'(rd_ack), 0);
    chk("mid_raddr",   int'(raddr), 0);
    chk("mid_rptr",    int'(rptr), 0);
    chk("mid_aempty",  int'(ralmost_empty), 1);

    for (int i = 0; i < 2000; i++) begin
      int occ;
      int adv;
      int w;
      bit r;
      @(negedge clk);
      #1;
      r = ($urandom_range(0, 199) == 0);
      if (r) begin
        w = $urandom_range(0, 3);
      end else begin
        occ = (wr_ptr - m.rd + PMOD) % PMOD;
        adv = $urandom_range(0, 2);
        if (occ + adv > DEPTH) adv = DEPTH - occ;
        w = wr_ptr + adv;
      end
      apply(r, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, w);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
